// File: rtl/ahb_resp_mux_if.sv
// ahb_resp_mux_if: AHB-Lite data-phase return bus between master/decoder, slaves and the response mux
interface ahb_resp_mux_if #(
  parameter int NSLV = 4,
  parameter int DW   = 32
);
  logic [NSLV-1:0]    HSEL;
  logic [1:0]         HTRANS;
  logic [NSLV*DW-1:0] HRDATA_S;
  logic [NSLV-1:0]    HREADYOUT_S;
  logic [NSLV-1:0]    HRESP_S;
  logic [DW-1:0]      HRDATA;
  logic               HREADY;
  logic               HRESP;

  modport slave (
    input  HSEL, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HRDATA, HREADY, HRESP
  );

  modport master (
    output HSEL, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB-Lite data-phase response mux with built-in default slave; optional error counter via AHB_MUX_ERRCNT_EN
module ahb_resp_mux #(
  parameter int NSLV = 4,
  parameter int DW   = 32
) (
  input  logic         HCLK,
  input  logic         HRESETn,
`ifdef AHB_MUX_ERRCNT_EN
  output logic [15:0]  DEF_ERR_CNT,
`endif
  ahb_resp_mux_if.slave bus
);
  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

  dstate_t         state, state_nx;
  logic [NSLV-1:0] dsel, hsel_low;
  logic [DW-1:0]   rdata;
  logic            ready_s, resp_s, unmapped;

  assign hsel_low = bus.HSEL & (~bus.HSEL + 1'b1);
  assign unmapped = bus.HTRANS[1] && (bus.HSEL == '0);

  // default-slave state and data-phase select, advanced only when an address phase is accepted
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= D_IDLE;
      dsel  <= '0;
    end else begin
      state <= state_nx;
      if (bus.HREADY) dsel <= hsel_low;
    end
  end

  // ERR1 always completes into ERR2; otherwise an accepted unmapped transfer starts a new error
  always_comb begin
    state_nx = state;
    if (state == D_ERR1) state_nx = D_ERR2;
    else if (bus.HREADY) state_nx = unmapped ? D_ERR1 : D_IDLE;
  end

  // one-hot AND-OR mux of the selected slave's response
  always_comb begin
    rdata   = '0;
    ready_s = 1'b0;
    resp_s  = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      rdata   = rdata | ({DW{dsel[i]}} & bus.HRDATA_S[i*DW +: DW]);
      ready_s = ready_s | (dsel[i] & bus.HREADYOUT_S[i]);
      resp_s  = resp_s | (dsel[i] & bus.HRESP_S[i]);
    end
  end

  assign bus.HRDATA = rdata;
  assign bus.HREADY = |dsel ? ready_s : (state != D_ERR1);
  assign bus.HRESP  = |dsel ? resp_s : (state != D_IDLE);

`ifdef AHB_MUX_ERRCNT_EN
  // saturating count of default-slave errors started
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) DEF_ERR_CNT <= '0;
    else if (state != D_ERR1 && state_nx == D_ERR1 && DEF_ERR_CNT != 16'hFFFF) DEF_ERR_CNT <= DEF_ERR_CNT + 16'd1;
  end
`endif
endmodule
